// File: rtl/buffer_ram_pkg.sv
// Shared types and constants for the byte-enable packet buffer.
package buffer_ram_pkg;

  // Clear-sweep controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Legal read latencies: output register only, or output plus pipeline register
  localparam int unsigned RD_LAT_REG  = 1;
  localparam int unsigned RD_LAT_PIPE = 2;

  // Number of byte lanes in a data word
  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/buffer_ram_be_core.sv
// Simple-dual-port byte-enable RAM, read-first, one-cycle registered read.
// The array itself has no reset so it maps onto block RAM; only the read
// output register has a synchronous clear.
module buffer_ram_core
  import buffer_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_be,
  input  logic                   rd_en,
  input  logic                   rd_clr,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data
);

  localparam int unsigned BE_W = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; lanes with a clear enable keep their old contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read; non-blocking update gives read-first on address collision
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/buffer_ram_be.sv
// Packet buffer: byte-enable write port, registered read port with 1 or 2
// cycle latency, read-valid strobe, and a one-word-per-cycle hardware clear
// sweep started by reset or clear_req.
module buffer_ram_be
  import buffer_ram_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DEPTH      = 2**ADDR_W,
  parameter int unsigned RD_LATENCY = RD_LAT_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      addr_wr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [DATA_W/8-1:0]    byte_en,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      addr_rd,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  input  logic                   clear_req,
  output logic                   busy
);

  localparam int unsigned BE_W = byte_lanes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_e             state;
  state_e             state_next;
  logic [ADDR_W-1:0]  clr_addr;
  logic [ADDR_W-1:0]  clr_addr_next;

  logic               wr_in_range;
  logic               rd_in_range;
  logic               rd_fire;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [BE_W-1:0]    mem_be;
  logic               mem_re;
  logic               mem_rclr;
  logic [DATA_W-1:0]  mem_q;

  logic               rd_v1;

  // Range checks; the extra bit lets DEPTH = 2**ADDR_W compare correctly
  assign wr_in_range = ({1'b0, addr_wr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, addr_rd} < DEPTH_EXT);

  // A read is accepted only in IDLE and never on a reset cycle
  assign rd_fire  = (state == ST_IDLE) && rd_en && !reset;
  assign mem_re   = rd_fire && rd_in_range;
  assign mem_rclr = reset || (rd_fire && !rd_in_range);

  // Clear FSM state register, sweep counter and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      busy     <= (state_next == ST_CLEAR);
    end
  end

  // Clear FSM next state: sweep every word once, then return to IDLE
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    unique case (state)
      ST_CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end
      default: begin
        state_next    = ST_CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  // Write-port mux: the sweep owns the port in CLEAR, user writes otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_wr;
    mem_wdata = data_in;
    mem_be    = byte_en;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end else begin
      mem_we    = wr_en && wr_in_range && !reset;
    end
  end

  buffer_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .wr_be   (mem_be),
    .rd_en   (mem_re),
    .rd_clr  (mem_rclr),
    .rd_addr (addr_rd),
    .rd_data (mem_q)
  );

  // First stage of the read-valid shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_fire;
    end
  end

  if (RD_LATENCY == RD_LAT_PIPE) begin : g_pipe
    logic [DATA_W-1:0] data_p2;
    logic              rd_v2;

    // Second pipeline stage; data only moves with a valid read so it holds otherwise
    always_ff @(posedge clk) begin
      if (reset) begin
        data_p2 <= '0;
        rd_v2   <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          data_p2 <= mem_q;
        end
      end
    end

    assign data_out = data_p2;
    assign rd_valid = rd_v2;
  end else begin : g_reg
    assign data_out = mem_q;
    assign rd_valid = rd_v1;
  end

endmodule

// File: tb/tb_buffer_ram_be.sv
// Scoreboard bench for buffer_ram_be: latency-1 and latency-2 DEPTH=16
// instances share stimulus; a DEPTH=12 instance is held in reset until the
// final out-of-range phase.
module tb_buffer_ram_be;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        reset3;
  logic        wr_en;
  logic [3:0]  addr_wr;
  logic [31:0] data_in;
  logic [3:0]  byte_en;
  logic        rd_en;
  logic [3:0]  addr_rd;
  logic        clear_req;

  logic [31:0] data_out1, data_out2, data_out3;
  logic        rd_valid1, rd_valid2, rd_valid3;
  logic        busy1, busy2, busy3;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  buffer_ram_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .addr_wr(addr_wr), .data_in(data_in),
    .byte_en(byte_en), .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out1),
    .rd_valid(rd_valid1), .clear_req(clear_req), .busy(busy1));

  buffer_ram_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .addr_wr(addr_wr), .data_in(data_in),
    .byte_en(byte_en), .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out2),
    .rd_valid(rd_valid2), .clear_req(clear_req), .busy(busy2));

  buffer_ram_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LATENCY(1)) u_d12 (
    .clk(clk), .reset(reset3), .wr_en(wr_en), .addr_wr(addr_wr), .data_in(data_in),
    .byte_en(byte_en), .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out3),
    .rd_valid(rd_valid3), .clear_req(clear_req), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pop(input int id);
    case (id)
      1:       q1.delete(0);
      2:       q2.delete(0);
      default: q3.delete(0);
    endcase
  endtask

  // Pops the oldest expected read whenever a port presents rd_valid
  task automatic mon(input int id, input logic v, input logic [31:0] d);
    exp_t e;
    int   sz;
    case (id)
      1:       sz = q1.size();
      2:       sz = q2.size();
      default: sz = q3.size();
    endcase
    e.data = '0;
    e.due  = 0;
    if (sz > 0) begin
      case (id)
        1:       e = q1[0];
        2:       e = q2[0];
        default: e = q3[0];
      endcase
    end
    if (v === 1'b1) begin
      n_cmp++;
      if (sz == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected port%0d: got rd_valid=1 data=%h at cycle %0d, required no read", id, d, cyc);
      end else begin
        pop(id);
        if (d !== e.data || cyc != e.due) begin
          n_bad++;
          $display("FAIL rd_data port%0d: got %h at cycle %0d, required %h at cycle %0d", id, d, cyc, e.data, e.due);
        end
      end
    end else if (sz > 0 && cyc > e.due) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_missing port%0d: got no rd_valid by cycle %0d, required %h at cycle %0d", id, cyc, e.data, e.due);
      pop(id);
    end
  endtask

  always @(negedge clk) begin
    mon(1, rd_valid1, data_out1);
    mon(2, rd_valid2, data_out2);
    mon(3, rd_valid3, data_out3);
  end

  task automatic quiet();
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    addr_wr = a;
    data_in = d;
    byte_en = be;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e12, input logic [31:0] e3, input bit use3);
    exp_t e;
    rd_en   = 1'b1;
    addr_rd = a;
    e.data = e12; e.due = cyc + 1; q1.push_back(e);
    e.data = e12; e.due = cyc + 2; q2.push_back(e);
    if (use3) begin
      e.data = e3; e.due = cyc + 1; q3.push_back(e);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Counts negedges with busy high on the two DEPTH=16 instances, bounded
  task automatic wait_busy(output int n1, output int n2);
    n1 = 0;
    n2 = 0;
    while ((busy1 || busy2) && (n1 < 64) && (n2 < 64)) begin
      if (busy1) n1++;
      if (busy2) n2++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy3(output int n);
    n = 0;
    while (busy3 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n1, n2, n3;
    reset = 1'b1; reset3 = 1'b1;
    quiet();
    addr_wr = '0; data_in = '0; byte_en = '0; addr_rd = '0;
    @(negedge clk);

    // Reset values
    chk("reset_busy1", 32'(busy1), 32'd1);
    chk("reset_busy2", 32'(busy2), 32'd1);
    chk("reset_busy3", 32'(busy3), 32'd1);
    chk("reset_valid1", 32'(rd_valid1), 32'd0);
    chk("reset_valid2", 32'(rd_valid2), 32'd0);
    chk("reset_dout1", data_out1, 32'h0);
    chk("reset_dout2", data_out2, 32'h0);

    // Sweep after reset with wr_en held: nothing may land
    wr_en = 1'b1; addr_wr = 4'd7; data_in = 32'hDEADBEEF; byte_en = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    wait_busy(n1, n2);
    quiet();
    chk("sweep_len_lat1", 32'(n1), 32'd16);
    chk("sweep_len_lat2", 32'(n2), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 32'h0, 1'b0);

    // Byte-enable merge and an all-disabled write
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd(4'd3, 32'hAA22CC44, 32'h0, 1'b0);

    // Same-cycle read and write: old word, then new word
    wr(4'd5, 32'h00000001, 4'hF);
    wr_en = 1'b1; addr_wr = 4'd5; data_in = 32'h00000002; byte_en = 4'hF;
    rd(4'd5, 32'h00000001, 32'h0, 1'b0);
    wr_en = 1'b0;
    rd(4'd5, 32'h00000002, 32'h0, 1'b0);

    // clear_req with a read in flight; strobes and clear_req held during the sweep
    wr(4'd9, 32'h12345678, 4'hF);
    clear_req = 1'b1;
    rd(4'd9, 32'h12345678, 32'h0, 1'b0);
    rd_en = 1'b1; addr_rd = 4'd9;
    wr_en = 1'b1; addr_wr = 4'd4; data_in = 32'hFFFFFFFF; byte_en = 4'hF;
    wait_busy(n1, n2);
    quiet();
    chk("clear_len_lat1", 32'(n1), 32'd16);
    chk("clear_len_lat2", 32'(n2), 32'd16);
    chk("clear_hold_dout1", data_out1, 32'h12345678);
    chk("clear_hold_dout2", data_out2, 32'h12345678);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 32'h0, 1'b0);

    // Reset at clr_addr = 9 restarts the sweep from zero
    wr(4'd2, 32'h5A5A5A5A, 4'hF);
    rd(4'd2, 32'h5A5A5A5A, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_dout1", data_out1, 32'h0);
    chk("midreset_dout2", data_out2, 32'h0);
    chk("midreset_busy1", 32'(busy1), 32'd1);
    reset = 1'b0;
    wait_busy(n1, n2);
    chk("restart_len_lat1", 32'(n1), 32'd16);
    chk("restart_len_lat2", 32'(n2), 32'd16);
    rd(4'd2, 32'h0, 32'h0, 1'b0);
    rd(4'd15, 32'h0, 32'h0, 1'b0);

    // DEPTH=12 instance: out-of-range write dropped, read returns zero with rd_valid
    reset3 = 1'b0;
    wait_busy3(n3);
    chk("sweep_len_d12", 32'(n3), 32'd12);
    wr(4'd13, 32'hCAFEF00D, 4'hF);
    wr(4'd11, 32'h0BADF00D, 4'hF);
    rd(4'd13, 32'hCAFEF00D, 32'h0, 1'b1);
    rd(4'd11, 32'h0BADF00D, 32'h0BADF00D, 1'b1);
    rd(4'd12, 32'h0, 32'h0, 1'b1);

    repeat (6) @(negedge clk);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_q2", 32'(q2.size()), 32'd0);
    chk("drain_q3", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
